// File: rtl/alt_vipvfr131_common_mm_pkg.sv
// Shared types and helpers for the VIP Avalon-MM burst master and its FIFOs.
package alt_vipvfr131_common_mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_WR_WAIT  = 2'd2,
    ST_WR_BURST = 2'd3
  } mm_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/alt_vipvfr131_common_sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; the head is valid
// whenever used != 0. DEPTH must be a power of two and at least 2.
module alt_vipvfr131_common_sync_fwft_fifo
  import alt_vipvfr131_common_mm_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      used
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      used_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      used_q <= used_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // NOTE: the storage array is deliberately not reset; used_q alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign used     = used_q;

  always @(posedge clock) begin
    if (!reset) begin
      assert (!(push && !pop && used_q == FULL_COUNT));
      assert (!(pop && used_q == '0));
    end
  end

endmodule

// File: rtl/alt_vipvfr131_common_avalon_mm_burst_master.sv
// Avalon-MM bursting master: splits read/write commands into bursts of at most MAX_BURST
// words, credit-limits reads by read-FIFO space and issues writes only when fully buffered.
module alt_vipvfr131_common_avalon_mm_burst_master
  import alt_vipvfr131_common_mm_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int BURST_WIDTH      = 6,
  parameter int MAX_BURST        = 16,
  parameter int LEN_WIDTH        = 16,
  parameter int RDATA_FIFO_DEPTH = 32,
  parameter int WDATA_FIFO_DEPTH = 32,
  parameter int READ_USED        = 1,
  parameter int WRITE_USED       = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  av_address,
  output logic [BURST_WIDTH-1:0] av_burstcount,
  output logic [DATA_WIDTH-1:0]  av_writedata,
  output logic                   av_write,
  output logic                   av_read,
  input  logic [DATA_WIDTH-1:0]  av_readdata,
  input  logic                   av_readdatavalid,
  input  logic                   av_waitrequest
);

  localparam int BYTE_SHIFT = clog2(DATA_WIDTH / 8);
  localparam int RCW        = clog2(RDATA_FIFO_DEPTH) + 1;
  localparam int WCW        = clog2(WDATA_FIFO_DEPTH) + 1;
  localparam logic [RCW-1:0] RDEPTH_CNT = RCW'(RDATA_FIFO_DEPTH);
  localparam logic [WCW-1:0] WDEPTH_CNT = WCW'(WDATA_FIFO_DEPTH);

  mm_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [RCW-1:0]         outstanding_q, outstanding_d;
  logic                   av_read_q, av_read_d;
  logic                   av_write_q, av_write_d;
  logic [ADDR_WIDTH-1:0]  av_address_q, av_address_d;
  logic [BURST_WIDTH-1:0] av_burstcount_q, av_burstcount_d;
  logic [BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic [BURST_WIDTH-1:0] blen;
  logic [RCW-1:0]         credit;
  logic [ADDR_WIDTH-1:0]  burst_bytes;
  logic [RCW-1:0]         rfifo_used;
  logic [WCW-1:0]         wfifo_used;
  logic [DATA_WIDTH-1:0]  rfifo_head;
  logic [DATA_WIDTH-1:0]  wfifo_head;
  logic                   rfifo_push, rfifo_pop, wfifo_push, wfifo_pop;
  logic                   rd_accept, wr_beat, last_burst;

  generate
    if (READ_USED != 0) begin : g_rd
      alt_vipvfr131_common_sync_fwft_fifo #(
        .DEPTH (RDATA_FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
      ) u_rd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rfifo_push),
        .push_data (av_readdata),
        .pop       (rfifo_pop),
        .pop_data  (rfifo_head),
        .used      (rfifo_used)
      );
    end else begin : g_no_rd
      assign rfifo_head = '0;
      assign rfifo_used = '0;
    end

    if (WRITE_USED != 0) begin : g_wr
      alt_vipvfr131_common_sync_fwft_fifo #(
        .DEPTH (WDATA_FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
      ) u_wr_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wfifo_push),
        .push_data (wr_data),
        .pop       (wfifo_pop),
        .pop_data  (wfifo_head),
        .used      (wfifo_used)
      );
    end else begin : g_no_wr
      assign wfifo_head = '0;
      assign wfifo_used = '0;
    end
  endgenerate

  assign rfifo_push  = (READ_USED != 0) && av_readdatavalid;
  assign rd_valid    = (rfifo_used != '0);
  assign rfifo_pop   = rd_valid && rd_ready;
  assign rd_data     = rfifo_head;

  assign wr_ready    = (WRITE_USED != 0) && (wfifo_used != WDEPTH_CNT);
  assign wfifo_push  = wr_valid && wr_ready;
  assign wr_beat     = av_write_q && !av_waitrequest;
  assign wfifo_pop   = wr_beat;

  assign rd_accept   = av_read_q && !av_waitrequest;
  assign blen        = (remaining_q > LEN_WIDTH'(MAX_BURST)) ? BURST_WIDTH'(MAX_BURST)
                                                             : BURST_WIDTH'(remaining_q);
  // Outstanding beats already own FIFO slots, so they count against the credit.
  assign credit      = RDEPTH_CNT - rfifo_used - outstanding_q;
  assign burst_bytes = ADDR_WIDTH'(av_burstcount_q) << BYTE_SHIFT;
  assign last_burst  = (remaining_q == LEN_WIDTH'(av_burstcount_q));

  assign outstanding_d = outstanding_q
                       + (rd_accept  ? RCW'(av_burstcount_q) : '0)
                       - (rfifo_push ? RCW'(1)               : '0);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    av_read_d       = av_read_q;
    av_write_d      = av_write_q;
    av_address_d    = av_address_q;
    av_burstcount_d = av_burstcount_q;
    beat_cnt_d      = beat_cnt_q;
    cmd_ready       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          if (cmd_len != '0) begin
            if (cmd_write && (WRITE_USED != 0))       state_d = ST_WR_WAIT;
            else if (!cmd_write && (READ_USED != 0))  state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_RD_ISSUE: begin
        if (av_read_q) begin
          if (!av_waitrequest) begin
            av_read_d   = 1'b0;
            remaining_d = remaining_q - LEN_WIDTH'(av_burstcount_q);
            cur_addr_d  = cur_addr_q + burst_bytes;
            if (last_burst) state_d = ST_IDLE;
          end
        end else if (32'(credit) >= 32'(blen)) begin
          av_read_d       = 1'b1;
          av_address_d    = cur_addr_q;
          av_burstcount_d = blen;
        end
      end

      ST_WR_WAIT: begin
        if (32'(wfifo_used) >= 32'(blen)) begin
          state_d         = ST_WR_BURST;
          av_write_d      = 1'b1;
          av_address_d    = cur_addr_q;
          av_burstcount_d = blen;
          beat_cnt_d      = '0;
        end
      end

      ST_WR_BURST: begin
        if (wr_beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == av_burstcount_q - 1'b1) begin
            av_write_d  = 1'b0;
            remaining_d = remaining_q - LEN_WIDTH'(av_burstcount_q);
            cur_addr_d  = cur_addr_q + burst_bytes;
            state_d     = last_burst ? ST_IDLE : ST_WR_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      outstanding_q   <= '0;
      av_read_q       <= 1'b0;
      av_write_q      <= 1'b0;
      av_address_q    <= '0;
      av_burstcount_q <= '0;
      beat_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      outstanding_q   <= outstanding_d;
      av_read_q       <= av_read_d;
      av_write_q      <= av_write_d;
      av_address_q    <= av_address_d;
      av_burstcount_q <= av_burstcount_d;
      beat_cnt_q      <= beat_cnt_d;
    end
  end

  assign av_read       = av_read_q;
  assign av_write      = av_write_q;
  assign av_address    = av_address_q;
  assign av_burstcount = av_burstcount_q;
  assign av_writedata  = wfifo_head;
  assign busy          = (state_q != ST_IDLE) || (outstanding_q != '0);

endmodule

// File: tb/tb_alt_vipvfr131_common_avalon_mm_burst_master.sv
// Directed bench for the Avalon-MM burst master: a small slave model returns read data
// one cycle after acceptance and logs every request; expectations are hand-derived.
module tb_alt_vipvfr131_common_avalon_mm_burst_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  cnt;
  } burst_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  cnt;
    logic [31:0] data;
  } wbeat_t;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic [31:0] av_address;
  logic [5:0]  av_burstcount;
  logic [31:0] av_writedata;
  logic        av_write;
  logic        av_read;
  logic [31:0] av_readdata;
  logic        av_readdatavalid;
  logic        av_waitrequest;

  burst_t      rd_bursts[$];
  wbeat_t      wr_beats[$];
  logic [31:0] rx_q[$];
  logic [31:0] pend_q[$];
  int          beats_sent;
  int          pops_target = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  alt_vipvfr131_common_avalon_mm_burst_master dut (
    .clock            (clock),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .wr_data          (wr_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .busy             (busy),
    .av_address       (av_address),
    .av_burstcount    (av_burstcount),
    .av_writedata     (av_writedata),
    .av_write         (av_write),
    .av_read          (av_read),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .av_waitrequest   (av_waitrequest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Slave model: samples requests at the falling edge, returns one read beat per cycle.
  initial begin
    burst_t b;
    wbeat_t w;
    av_readdatavalid = 1'b0;
    av_readdata      = '0;
    beats_sent       = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend_q.delete();
        av_readdatavalid = 1'b0;
      end else begin
        if (pend_q.size() > 0) begin
          av_readdata      = pend_q.pop_front();
          av_readdatavalid = 1'b1;
          beats_sent++;
        end else begin
          av_readdatavalid = 1'b0;
        end
        if (av_read && !av_waitrequest) begin
          b.addr = av_address;
          b.cnt  = av_burstcount;
          rd_bursts.push_back(b);
          for (int i = 0; i < int'(av_burstcount); i++)
            pend_q.push_back(mem_word(av_address + 32'(4 * i)));
        end
        if (av_write && !av_waitrequest) begin
          w.addr = av_address;
          w.cnt  = av_burstcount;
          w.data = av_writedata;
          wr_beats.push_back(w);
        end
      end
    end
  end

  // Read-data consumer: pops until rx_q has pops_target entries.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      rd_ready = (rx_q.size() < pops_target);
      @(negedge clock);
      if (rd_valid && rd_ready && !reset) rx_q.push_back(rd_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input string tag, input logic w, input logic [31:0] a,
                          input logic [15:0] l, output int waited);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    waited    = 0;
    while (!cmd_ready && waited < 200) begin
      tick();
      waited++;
    end
    tick();
    cmd_valid = 1'b0;
    check({tag, "_cmd_accept"}, waited < 200, 1'b1);
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    int guard;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      guard    = 0;
      while (!wr_ready && guard < 200) begin
        tick();
        guard++;
      end
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    int c = 0;
    while (rx_q.size() < target && c < budget) begin
      tick();
      c++;
    end
    check({tag, "_rx_count"}, rx_q.size() >= target, 1'b1);
  endtask

  task automatic wait_wbeats(input string tag, input int target, input int budget);
    int c = 0;
    while (wr_beats.size() < target && c < budget) begin
      tick();
      c++;
    end
    check({tag, "_wbeat_count"}, wr_beats.size() >= target, 1'b1);
  endtask

  initial begin
    int          waited;
    int          rb, xb, wb, bs, c;
    logic        seen;
    logic [31:0] exp_addr [3];
    logic [5:0]  exp_cnt  [3];

    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_write      = 1'b0;
    cmd_addr       = '0;
    cmd_len        = '0;
    wr_data        = '0;
    wr_valid       = 1'b0;
    av_waitrequest = 1'b0;
    repeat (3) tick();

    check("rst_av_read",   av_read,       1'b0);
    check("rst_av_write",  av_write,      1'b0);
    check("rst_av_addr",   av_address,    32'h0);
    check("rst_av_count",  av_burstcount, 6'd0);
    check("rst_rd_valid",  rd_valid,      1'b0);
    check("rst_busy",      busy,          1'b0);
    reset = 1'b0;
    check("rst_cmd_ready", cmd_ready,     1'b1);
    check("rst_wr_ready",  wr_ready,      1'b1);

    // 1: 40-word read splits into 16/16/8.
    pops_target = 1 << 30;
    rb = rd_bursts.size();
    xb = rx_q.size();
    send_cmd("t1", 1'b0, 32'h1000, 16'd40, waited);
    wait_rx("t1", xb + 40, 400);
    check("t1_burst_num", rd_bursts.size() - rb, 3);
    exp_addr = '{32'h1000, 32'h1040, 32'h1080};
    exp_cnt  = '{6'd16, 6'd16, 6'd8};
    if (rd_bursts.size() >= rb + 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t1_burst_addr", rd_bursts[rb + i].addr, exp_addr[i]);
        check("t1_burst_cnt",  rd_bursts[rb + i].cnt,  exp_cnt[i]);
      end
    end
    if (rx_q.size() >= xb + 40)
      for (int i = 0; i < 40; i++)
        check("t1_data", rx_q[xb + i], mem_word(32'h1000 + 32'(4 * i)));
    repeat (3) tick();
    check("t1_busy_end",  busy,     1'b0);
    check("t1_rd_valid0", rd_valid, 1'b0);

    // 2: credit limit with rd_ready low.
    pops_target = rx_q.size();
    xb = rx_q.size();
    rb = rd_bursts.size();
    send_cmd("t2", 1'b0, 32'h1000, 16'd64, waited);
    repeat (80) tick();
    check("t2_bursts_stalled", rd_bursts.size() - rb, 2);
    check("t2_av_read_low",    av_read,  1'b0);
    check("t2_rd_valid",       rd_valid, 1'b1);
    pops_target = xb + 16;
    wait_rx("t2_pop16", xb + 16, 100);
    c = 0;
    while (rd_bursts.size() < rb + 3 && c < 50) begin
      tick();
      c++;
    end
    check("t2_third_issued", rd_bursts.size() >= rb + 3, 1'b1);
    if (rd_bursts.size() >= rb + 3) begin
      check("t2_third_addr", rd_bursts[rb + 2].addr, 32'h1080);
      check("t2_third_cnt",  rd_bursts[rb + 2].cnt,  6'd16);
    end
    pops_target = 1 << 30;
    wait_rx("t2_all", xb + 64, 800);
    check("t2_burst_num", rd_bursts.size() - rb, 4);
    if (rd_bursts.size() >= rb + 4)
      check("t2_fourth_addr", rd_bursts[rb + 3].addr, 32'h10C0);
    if (rx_q.size() >= xb + 64)
      for (int i = 0; i < 64; i++)
        check("t2_data", rx_q[xb + i], mem_word(32'h1000 + 32'(4 * i)));
    repeat (3) tick();
    check("t2_busy_end", busy, 1'b0);

    // 3: write is held until a whole burst is buffered.
    wb = wr_beats.size();
    send_cmd("t3", 1'b1, 32'h2000, 16'd20, waited);
    push_words(10, 32'hB000_0000);
    repeat (10) tick();
    check("t3_no_beats_10", wr_beats.size() - wb, 0);
    check("t3_no_write_10", av_write, 1'b0);
    push_words(6, 32'hB000_000A);
    wait_wbeats("t3_b16", wb + 16, 100);
    if (wr_beats.size() >= wb + 16) begin
      check("t3_b16_addr_first", wr_beats[wb].addr,      32'h2000);
      check("t3_b16_cnt_first",  wr_beats[wb].cnt,       6'd16);
      check("t3_b16_addr_last",  wr_beats[wb + 15].addr, 32'h2000);
      check("t3_b16_cnt_last",   wr_beats[wb + 15].cnt,  6'd16);
      for (int i = 0; i < 16; i++)
        check("t3_b16_data", wr_beats[wb + i].data, 32'hB000_0000 + 32'(i));
    end
    push_words(4, 32'hB000_0010);
    wait_wbeats("t3_b4", wb + 20, 100);
    if (wr_beats.size() >= wb + 20) begin
      for (int i = 16; i < 20; i++) begin
        check("t3_b4_addr", wr_beats[wb + i].addr, 32'h2040);
        check("t3_b4_cnt",  wr_beats[wb + i].cnt,  6'd4);
        check("t3_b4_data", wr_beats[wb + i].data, 32'hB000_0000 + 32'(i));
      end
    end
    repeat (3) tick();
    check("t3_extra_beats", wr_beats.size() - wb, 20);
    check("t3_busy_end",    busy, 1'b0);

    // 4: waitrequest stall on the first write beat.
    wb = wr_beats.size();
    send_cmd("t4", 1'b1, 32'h3000, 16'd16, waited);
    av_waitrequest = 1'b1;
    push_words(16, 32'hC000_0000);
    c = 0;
    while (!av_write && c < 50) begin
      tick();
      c++;
    end
    check("t4_write_rise", av_write, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stall_write", av_write,      1'b1);
      check("t4_stall_addr",  av_address,    32'h3000);
      check("t4_stall_cnt",   av_burstcount, 6'd16);
      check("t4_stall_data",  av_writedata,  32'hC000_0000);
    end
    check("t4_no_beats_stalled", wr_beats.size() - wb, 0);
    av_waitrequest = 1'b0;
    wait_wbeats("t4", wb + 16, 100);
    if (wr_beats.size() >= wb + 16)
      for (int i = 0; i < 16; i++)
        check("t4_data", wr_beats[wb + i].data, 32'hC000_0000 + 32'(i));
    repeat (3) tick();
    check("t4_busy_end", busy, 1'b0);

    // 5: zero-length command is consumed without any bus activity.
    rb = rd_bursts.size();
    send_cmd("t5", 1'b0, 32'h5000, 16'd0, waited);
    check("t5_accept_latency", waited, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | av_read | av_write | busy;
      tick();
    end
    check("t5_no_activity", seen, 1'b0);
    check("t5_no_bursts",   rd_bursts.size() - rb, 0);
    check("t5_cmd_ready",   cmd_ready, 1'b1);

    // 6: reset in the middle of a read burst.
    pops_target = 1 << 30;
    bs = beats_sent;
    send_cmd("t6", 1'b0, 32'h4000, 16'd16, waited);
    c = 0;
    while (beats_sent < bs + 3 && c < 100) begin
      @(negedge clock);
      #1;
      c++;
    end
    check("t6_reached_beat3", beats_sent >= bs + 3, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t6_rst_av_read",  av_read,  1'b0);
    check("t6_rst_rd_valid", rd_valid, 1'b0);
    check("t6_rst_busy",     busy,     1'b0);
    @(negedge clock);
    tick();
    reset = 1'b0;
    check("t6_cmd_ready", cmd_ready, 1'b1);
    check("t6_wr_ready",  wr_ready,  1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | rd_valid | busy | av_read;
    end
    check("t6_quiet_after", seen, 1'b0);

    xb = rx_q.size();
    send_cmd("t6_recover", 1'b0, 32'h6000, 16'd4, waited);
    wait_rx("t6_recover", xb + 4, 100);
    if (rx_q.size() >= xb + 4)
      for (int i = 0; i < 4; i++)
        check("t6_recover_data", rx_q[xb + i], mem_word(32'h6000 + 32'(4 * i)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
